// File: rtl/mealy_fsm_if.sv
// rtl/mealy_fsm_if.sv - serial bit stream and detection status bundle for mealy_fsm
interface mealy_fsm_if #(
    parameter int CNT_W = 8
);
    logic             valid;
    logic             d_in;
    logic             pattern_detect;
    logic [CNT_W-1:0] match_count;

    modport master (
        output valid,
        output d_in,
        input  pattern_detect,
        input  match_count
    );

    modport slave (
        input  valid,
        input  d_in,
        output pattern_detect,
        output match_count
    );
endinterface

// File: rtl/mealy_fsm.sv
// rtl/mealy_fsm.sv - Mealy detector for serial pattern 110101 with saturating match counter
// Define MEALY_FSM_OVERLAP_EN to let the trailing 1 of a match start the next one.
module mealy_fsm #(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        res,
    mealy_fsm_if.slave  bus
);

    // Each state names the longest prefix of 110101 seen so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             detect;
    logic [CNT_W-1:0] count_q;

`ifdef MEALY_FSM_OVERLAP_EN
    localparam state_t AFTER_MATCH = S1;
`else
    localparam state_t AFTER_MATCH = S0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        detect  = 1'b0;
        case (state_q)
            S0: if (bus.valid) state_d = bus.d_in ? S1 : S0;
            S1: if (bus.valid) state_d = bus.d_in ? S2 : S0;
            S2: if (bus.valid) state_d = bus.d_in ? S2 : S3;
            S3: if (bus.valid) state_d = bus.d_in ? S4 : S0;
            S4: if (bus.valid) state_d = bus.d_in ? S2 : S5;
            S5: begin
                if (bus.valid) begin
                    if (bus.d_in) begin
                        detect  = 1'b1;
                        state_d = AFTER_MATCH;
                    end else begin
                        state_d = S0;
                    end
                end
            end
            // Unused encodings fall back to idle even without a valid bit.
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            count_q <= '0;
        end else if (detect && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.pattern_detect = detect;
    assign bus.match_count    = count_q;

endmodule

// File: tb/tb_mealy_fsm.sv
// tb/tb_mealy_fsm.sv - directed and random stimulus for mealy_fsm against a sliding-window model
module tb_mealy_fsm;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic valid = 1'b0;
    logic d_in = 1'b0;

    int checks = 0;
    int failures = 0;

    bit hist[$];
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    mealy_fsm_if #(.CNT_W(8)) bus8 ();
    mealy_fsm_if #(.CNT_W(2)) bus2 ();

    assign bus8.valid = valid;
    assign bus8.d_in  = d_in;
    assign bus2.valid = valid;
    assign bus2.d_in  = d_in;

    mealy_fsm #(.CNT_W(8)) dut8 (.clk(clk), .res(res), .bus(bus8));
    mealy_fsm #(.CNT_W(2)) dut2 (.clk(clk), .res(res), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit window_match(input bit d);
        bit [5:0] w;
        if (hist.size() < 5) return 1'b0;
        for (int i = 0; i < 5; i++) w[5-i] = hist[hist.size()-5+i];
        w[0] = d;
        return w == 6'b110101;
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_cnt8 = 0;
        exp_cnt2 = 0;
    endtask

    task automatic step(input bit v, input bit d, input string tag);
        bit exp_det;
        @(negedge clk);
        valid = v;
        d_in  = d;
        #1;
        exp_det = v && window_match(d);
        check({tag, "_det8"}, {31'd0, bus8.pattern_detect}, {31'd0, exp_det});
        check({tag, "_det2"}, {31'd0, bus2.pattern_detect}, {31'd0, exp_det});
        check({tag, "_cnt8"}, {24'd0, bus8.match_count}, exp_cnt8);
        check({tag, "_cnt2"}, {30'd0, bus2.match_count}, exp_cnt2);
        @(posedge clk);
        if (v) begin
            hist.push_back(d);
            while (hist.size() > 5) void'(hist.pop_front());
        end
        if (exp_det) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
`ifndef MEALY_FSM_OVERLAP_EN
            hist.delete();
`endif
        end
    endtask

    task automatic send(input string bits, input string tag);
        for (int i = 0; i < bits.len(); i++) step(1'b1, bits[i] == "1", tag);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        valid = 1'b0;
        #1;
        check({tag, "_cnt8"}, {24'd0, bus8.match_count}, exp_cnt8);
        check({tag, "_cnt2"}, {30'd0, bus2.match_count}, exp_cnt2);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        valid = 1'b1;
        d_in  = 1'b1;
        #2;
        res = 1'b0;
        #1;
        model_clear();
        check({tag, "_det8"}, {31'd0, bus8.pattern_detect}, 32'd0);
        check({tag, "_cnt8"}, {24'd0, bus8.match_count}, 32'd0);
        check({tag, "_cnt2"}, {30'd0, bus2.match_count}, 32'd0);
        @(negedge clk);
        res = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_det", {31'd0, bus8.pattern_detect}, 32'd0);
        check("reset_cnt8", {24'd0, bus8.match_count}, 32'd0);
        check("reset_cnt2", {30'd0, bus2.match_count}, 32'd0);
        @(negedge clk);
        res = 1'b1;

        send("110101", "basic");
        idle_check("basic_after");
        check("basic_total", {24'd0, bus8.match_count}, 32'd1);

        async_reset("rst_a");
        send("11010110101", "overlap");
        idle_check("overlap_after");
`ifdef MEALY_FSM_OVERLAP_EN
        check("overlap_total", {24'd0, bus8.match_count}, 32'd2);
`else
        check("overlap_total", {24'd0, bus8.match_count}, 32'd1);
`endif

        async_reset("rst_b");
        send("1110101", "s2_loop");
        send("0", "sep");
        send("110110101", "s4_loop");
        idle_check("loop_after");
        check("loop_total", {24'd0, bus8.match_count}, 32'd2);

        send("00", "gap_pre");
        send("11010", "gap_head");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "gap_hold");
        step(1'b1, 1'b1, "gap_tail");

        send("11010", "mid_head");
        async_reset("mid_rst");
        step(1'b1, 1'b1, "mid_after");
        send("0", "mid_sep");

        async_reset("sat_rst");
        for (int k = 0; k < 5; k++) send("0110101", "sat");
        idle_check("sat_after");
        check("sat_cnt2", {30'd0, bus2.match_count}, 32'd3);
        check("sat_cnt8", {24'd0, bus8.match_count}, 32'd5);

        for (int i = 0; i < 3000; i++) begin
            automatic bit v = ($urandom_range(0, 3) != 0);
            automatic bit d = ($urandom_range(0, 9) < 6);
            step(v, d, "rand");
        end
        idle_check("rand_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
